// File: rtl/addsub_pkg.sv
// -----------------------------------------------------------------------------
// addsub_pkg
// Shared definitions for the pipelined add/subtract unit:
//   - seg_w / nblk : geometry helpers used to size localparams
//   - cfg_ok       : legality check for (WIDTH, BLOCK, STAGES)
//   - flags_t      : condition flags presented with each result
// -----------------------------------------------------------------------------
package addsub_pkg;

  typedef struct packed {
    logic c;     // carry out of the MSB (subtract: 1 = no borrow)
    logic ovf;   // two's-complement overflow
    logic zero;  // result is all zeros
    logic neg;   // result MSB
  } flags_t;

  // Bits handled by one pipeline stage.
  function automatic int seg_w(input int width, input int stages);
    return width / stages;
  endfunction

  // Carry blocks per pipeline stage.
  function automatic int nblk(input int seg, input int block);
    return seg / block;
  endfunction

  // Every stage must hold a whole number of carry blocks.
  function automatic bit cfg_ok(input int width, input int block, input int stages);
    return (block >= 1) && (stages >= 1) && (width >= 1) &&
           ((width % (block * stages)) == 0);
  endfunction

endpackage

// File: rtl/cla_block.sv
// -----------------------------------------------------------------------------
// cla_block
// BLOCK-bit generate/propagate adder slice.
//   a, b   : operand bits (b already inverted for subtract)
//   ci     : carry into bit 0
//   s      : sum bits
//   co     : carry out of bit BLOCK-1
//   c_msb  : carry into bit BLOCK-1 (XOR with co gives signed overflow when
//            this slice holds the word MSB)
// -----------------------------------------------------------------------------
module cla_block #(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             ci,
  output logic [BLOCK-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [BLOCK-1:0] g;
  logic [BLOCK-1:0] p;
  logic [BLOCK:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  // Unrolled by synthesis into the flat lookahead terms c[i+1] = g | p&c.
  always_comb begin
    // NOTE: c[0] is assigned first and the loop writes every higher bit, so
    // each bit of c is driven on every evaluation and no latch is inferred.
    c[0] = ci;
    for (int i = 0; i < BLOCK; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
  end

  assign s     = p ^ c[BLOCK-1:0];
  assign co    = c[BLOCK];
  assign c_msb = c[BLOCK-1];

endmodule

// File: rtl/pipe_addsub.sv
// -----------------------------------------------------------------------------
// pipe_addsub
// Pipelined add/subtract unit with valid/ready on both sides.
//   Parameters: WIDTH (operand width), BLOCK (carry block size),
//               STAGES (pipeline register stages, 1..WIDTH/BLOCK)
//   Input side : i_valid / o_ready, operands i_va, i_vb, i_c0 (carry/borrow
//                in), i_sub (0 add, 1 subtract)
//   Output side: o_valid / i_ready, result o_v and flags o_c, o_ovf,
//                o_zero, o_neg (flags derived from the final stage registers)
//   Clock/reset: i_clk rising edge, i_rst_n asynchronous active-low
//
// The word is cut into STAGES segments. Stage k adds segment k using the
// carry registered by stage k-1; the untouched upper operand bits and the
// already finished lower result bits ride along in the stage registers.
// The whole pipe advances together whenever the output is empty or taken.
// -----------------------------------------------------------------------------
module pipe_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int BLOCK  = 4,
  parameter int STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_va,
  input  logic [WIDTH-1:0] i_vb,
  input  logic             i_c0,
  input  logic             i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_v,
  output logic             o_c,
  output logic             o_ovf,
  output logic             o_zero,
  output logic             o_neg
);

  localparam int SEG  = seg_w(WIDTH, STAGES);
  localparam int NB   = nblk(SEG, BLOCK);
  localparam int LAST = STAGES - 1;

  if (!cfg_ok(WIDTH, BLOCK, STAGES)) begin : g_cfg_check
    $error("pipe_addsub: WIDTH must be a positive multiple of BLOCK*STAGES");
  end

  // A single advance for every stage: bubbles are only squeezed at the output.
  logic advance;
  assign advance = !o_valid || i_ready;
  assign o_ready = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] r_in;
    logic             c_in;
    logic             v_in;

    logic [NB:0]      cc;     // carry chain through this stage's blocks
    logic [NB-1:0]    cm;     // carry into each block's top bit
    logic [SEG-1:0]   seg_s;
    logic [WIDTH-1:0] r_nx;

    logic             v_q;
    logic             c_q;
    logic             cm_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] r_q;

    if (k == 0) begin : g_head
      // Subtract is A + ~B + !borrow, so both inversions happen once here.
      assign a_in = i_va;
      assign b_in = i_vb ^ {WIDTH{i_sub}};
      assign c_in = i_c0 ^ i_sub;
      assign r_in = '0;
      assign v_in = i_valid;
    end else begin : g_body
      assign a_in = g_stg[k-1].a_q;
      assign b_in = g_stg[k-1].b_q;
      assign c_in = g_stg[k-1].c_q;
      assign r_in = g_stg[k-1].r_q;
      assign v_in = g_stg[k-1].v_q;
    end

    assign cc[0] = c_in;

    for (genvar j = 0; j < NB; j++) begin : g_blk
      cla_block #(
        .BLOCK (BLOCK)
      ) u_cla (
        .a     (a_in[k*SEG + j*BLOCK +: BLOCK]),
        .b     (b_in[k*SEG + j*BLOCK +: BLOCK]),
        .ci    (cc[j]),
        .s     (seg_s[j*BLOCK +: BLOCK]),
        .co    (cc[j+1]),
        .c_msb (cm[j])
      );
    end

    // Merge this stage's segment into the result bits carried so far.
    always_comb begin
      r_nx = r_in;
      r_nx[k*SEG +: SEG] = seg_s;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        // NOTE: data registers are cleared as well as the valid bit, so the
        // derived flags read as a clean zero result straight out of reset.
        v_q  <= 1'b0;
        c_q  <= 1'b0;
        cm_q <= 1'b0;
        a_q  <= '0;
        b_q  <= '0;
        r_q  <= '0;
      end else if (advance) begin
        // NOTE: non-blocking so every stage loads its predecessor's value
        // from before this edge, independent of block evaluation order.
        v_q <= v_in;
        // Bubbles move the valid bit only; payload registers keep their value.
        if (v_in) begin
          a_q  <= a_in;
          b_q  <= b_in;
          r_q  <= r_nx;
          c_q  <= cc[NB];
          cm_q <= cm[NB-1];
        end
      end
    end

    // Operand bits below the current segment, the last stage's operand copy
    // and the inner-block MSB carries are structurally dead; sink them here.
    logic unused_stg;
    assign unused_stg = ^{a_in, b_in, a_q, b_q, cm, cm_q};
  end

  flags_t flags;

  assign flags.c    = g_stg[LAST].c_q;
  assign flags.ovf  = g_stg[LAST].c_q ^ g_stg[LAST].cm_q;
  assign flags.zero = (g_stg[LAST].r_q == '0);
  assign flags.neg  = g_stg[LAST].r_q[WIDTH-1];

  assign o_valid = g_stg[LAST].v_q;
  assign o_v     = g_stg[LAST].r_q;
  assign o_c     = flags.c;
  assign o_ovf   = flags.ovf;
  assign o_zero  = flags.zero;
  assign o_neg   = flags.neg;

endmodule

// File: tb/tb_pipe_addsub.sv
// -----------------------------------------------------------------------------
// tb_pipe_addsub
// Four independent harnesses, one per (WIDTH, BLOCK, STAGES) configuration,
// share a clock. Each one runs reset checks, a latency probe, directed corner
// operands, a backpressure burst, a mid-stream reset and a random stream.
// The driver pushes the expected response on every accepted operand set; a
// monitor pops and compares whenever a result transfers.
// -----------------------------------------------------------------------------
module tb_pipe_addsub;

  localparam int NCFG  = 4;
  localparam int NRAND = 10000;

  typedef struct packed {
    logic [63:0] v;
    logic [3:0]  f;   // {c, ovf, zero, neg}
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int check_cnt = 0;
  int pass_cnt  = 0;

  task automatic check(input bit ok, input string nm,
                       input logic [63:0] act, input logic [63:0] req);
    check_cnt++;
    if (ok) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, wanted 0x%0h (t=%0t)", nm, act, req, $time);
  endtask

  // Reference: exact integer arithmetic on wide signed values, reduced
  // modulo 2^w at the end. Carry and overflow come from range tests.
  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                 input bit c0, input bit sub, input int w);
    logic signed [67:0] md, ua, ub, sa, sb, ci, ures, sres;
    exp_t e;
    md = 68'sd1 <<< w;
    ua = $signed({4'b0, a}) & (md - 68'sd1);
    ub = $signed({4'b0, b}) & (md - 68'sd1);
    sa = ua[w-1] ? ua - md : ua;
    sb = ub[w-1] ? ub - md : ub;
    ci = c0 ? 68'sd1 : 68'sd0;
    if (!sub) begin
      ures   = ua + ub + ci;
      sres   = sa + sb + ci;
      e.f[3] = (ures >= md);
    end else begin
      ures   = ua - ub - ci;
      sres   = sa - sb - ci;
      e.f[3] = (ures >= 68'sd0);
    end
    ures   = ures & (md - 68'sd1);
    e.v    = ures[63:0];
    e.f[2] = (sres >= (md >>> 1)) || (sres < -(md >>> 1));
    e.f[1] = (e.v == 64'd0);
    e.f[0] = e.v[w-1];
    return e;
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 7))
      0:       return 64'd0;
      1:       return {64{1'b1}};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int W = (g == 0) ? 32 : (g == 1) ? 8 : (g == 2) ? 16 : 64;
    localparam int B = (g == 0) ? 4  : (g == 1) ? 4 : (g == 2) ? 2  : 8;
    localparam int S = (g == 0) ? 2  : (g == 1) ? 1 : (g == 2) ? 4  : 8;

    logic         rst_n, valid, rdy, c0, sub;
    logic         o_ready, o_valid, o_c, o_ovf, o_zero, o_neg;
    logic [W-1:0] va, vb, o_v;

    exp_t        q[$];
    bit          fin = 1'b0;
    bit          rand_done;
    bit          prev_stall = 1'b0;
    logic [63:0] prev_v;
    logic [3:0]  prev_f;

    pipe_addsub #(
      .WIDTH  (W),
      .BLOCK  (B),
      .STAGES (S)
    ) u_dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_valid (valid),
      .o_ready (o_ready),
      .i_va    (va),
      .i_vb    (vb),
      .i_c0    (c0),
      .i_sub   (sub),
      .o_valid (o_valid),
      .i_ready (rdy),
      .o_v     (o_v),
      .o_c     (o_c),
      .o_ovf   (o_ovf),
      .o_zero  (o_zero),
      .o_neg   (o_neg)
    );

    function automatic string tag(input string nm);
      return $sformatf("cfg%0d(W%0d,B%0d,S%0d) %s", g, W, B, S, nm);
    endfunction

    // Monitor: handshake rule, stall stability and in-order scoreboard.
    always @(negedge clk) begin : mon
      exp_t       e;
      logic [3:0] act_f;
      act_f = {o_c, o_ovf, o_zero, o_neg};
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        check(o_ready == !(o_valid && !rdy), tag("o_ready"),
              64'(o_ready), 64'(!(o_valid && !rdy)));
        if (prev_stall) begin
          check(o_valid && (64'(o_v) == prev_v) && (act_f == prev_f),
                tag("stall_hold"), 64'(o_v), prev_v);
        end
        if (o_valid && rdy) begin
          if (q.size() == 0) begin
            check(1'b0, tag("unexpected_result"), 64'(o_v), 64'd0);
          end else begin
            e = q.pop_front();
            check(64'(o_v) == e.v, tag("result"), 64'(o_v), e.v);
            check(act_f == e.f, tag("flags"), 64'(act_f), 64'(e.f));
          end
        end
        prev_stall = o_valid && !rdy;
        prev_v     = 64'(o_v);
        prev_f     = act_f;
      end
    end

    // Hold one operand set until it is accepted; the expected response is
    // queued at the negedge preceding the accepting edge.
    task automatic send(input logic [63:0] a, input logic [63:0] b,
                        input bit cin, input bit s);
      bit acc = 1'b0;
      va = W'(a); vb = W'(b); c0 = cin; sub = s; valid = 1'b1;
      for (int n = 0; n < 2000 && !acc; n++) begin
        @(negedge clk);
        if (o_ready) begin
          acc = 1'b1;
          q.push_back(model(64'(va), 64'(vb), c0, sub, W));
        end
        @(posedge clk); #1;
      end
      check(acc, tag("accept"), 64'(acc), 64'd1);
      valid = 1'b0;
    endtask

    task automatic drain();
      rdy = 1'b1;
      for (int n = 0; n < 300 && q.size() != 0; n++) @(negedge clk);
      @(posedge clk); #1;
      check(q.size() == 0, tag("drain"), 64'(q.size()), 64'd0);
    endtask

    initial begin : drv
      logic [63:0] all1, maxpos;
      int          lat;
      all1   = {64{1'b1}} >> (64 - W);
      maxpos = all1 >> 1;

      rst_n = 1'b0; valid = 1'b0; rdy = 1'b1;
      va = '0; vb = '0; c0 = 1'b0; sub = 1'b0;
      repeat (2) @(negedge clk);
      check(o_valid == 1'b0, tag("rst_valid"), 64'(o_valid), 64'd0);
      check(o_v == '0, tag("rst_v"), 64'(o_v), 64'd0);
      check({o_c, o_ovf, o_zero, o_neg} == 4'b0010, tag("rst_flags"),
            64'({o_c, o_ovf, o_zero, o_neg}), 64'h2);
      rst_n = 1'b1;
      @(negedge clk);
      check(o_ready == 1'b1, tag("ready_after_rst"), 64'(o_ready), 64'd1);
      @(posedge clk); #1;

      // Latency probe: count cycles from the accept cycle to o_valid.
      send(64'd5, 64'd3, 1'b0, 1'b0);
      lat = 0;
      for (int n = 1; n <= S + 10; n++) begin
        @(negedge clk);
        if (o_valid) begin
          lat = n;
          break;
        end
      end
      check(lat == S, tag("latency"), 64'(lat), 64'(S));
      @(posedge clk); #1;

      // Corner operands, back to back.
      send(all1, 64'd0, 1'b1, 1'b0);         // carry through every block
      send(maxpos, 64'd1, 1'b0, 1'b0);       // positive overflow
      send(64'd3, 64'd5, 1'b0, 1'b1);        // borrow, negative result
      send(64'd5, 64'd3, 1'b1, 1'b1);        // subtract with borrow-in
      send(maxpos + 64'd1, 64'd1, 1'b0, 1'b1); // negative overflow
      send(64'd0, 64'd0, 1'b0, 1'b1);        // 0 - 0: zero, no borrow
      drain();

      // Backpressure: six back-to-back ops, output blocked on cycles 3..7.
      fork
        begin
          for (int i = 0; i < 6; i++) send(pick(), pick(), 1'($urandom), 1'($urandom));
        end
        begin
          repeat (3) @(posedge clk);
          #1 rdy = 1'b0;
          repeat (5) @(posedge clk);
          #1 rdy = 1'b1;
        end
      join
      drain();

      // Reset with two operations in flight: both must vanish.
      send(pick(), pick(), 1'b0, 1'b0);
      send(pick(), pick(), 1'b1, 1'b1);
      rst_n = 1'b0;
      #1;
      check(o_valid == 1'b0, tag("async_flush"), 64'(o_valid), 64'd0);
      q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (S + 4) @(negedge clk);
      check(o_valid == 1'b0, tag("no_ghost"), 64'(o_valid), 64'd0);
      @(posedge clk); #1;

      // Random stream with random input gaps and output backpressure.
      rand_done = 1'b0;
      fork
        begin
          for (int i = 0; i < NRAND; i++) begin
            if ($urandom_range(0, 2) == 0) begin
              @(posedge clk); #1;
            end
            send(pick(), pick(), 1'($urandom), 1'($urandom));
          end
          rand_done = 1'b1;
        end
        begin
          while (!rand_done) begin
            @(posedge clk); #1;
            rdy = ($urandom_range(0, 3) != 0);
          end
        end
      join
      drain();
      fin = 1'b1;
    end
  end

  logic all_fin;
  assign all_fin = g_cfg[0].fin & g_cfg[1].fin & g_cfg[2].fin & g_cfg[3].fin;

  initial begin
    for (int n = 0; n < 90000 && !all_fin; n++) @(posedge clk);
    check(all_fin, "global_timeout", 64'(all_fin), 64'd1);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
